// File: rtl/bsg_round_robin_1_to_n_buf.sv
// bsg_round_robin_1_to_n_buf
//   Takes a single upstream valid/ready stream, buffers it in a 2-entry FIFO
//   and hands the words out to num_out_p downstream channels in round-robin
//   order. In strict mode every channel gets its turn in sequence. In skip
//   mode the first ready channel at or after the pointer is served.
//
// Ports
//   clk_i      : clock, all state changes on the rising edge
//   reset_n_i  : asynchronous active-low reset
//   valid_i    : upstream word valid
//   data_i     : upstream payload
//   ready_o    : a word can be accepted this cycle (registered state only)
//   valid_o    : one-hot (or zero) valid, one bit per downstream channel
//   data_o     : FIFO head, broadcast to every channel
//   ready_i    : per-channel downstream ready
//   ptr_o      : current rotation pointer
module bsg_round_robin_1_to_n_buf #(
    parameter int num_out_p        = 4,
    parameter int width_p          = 8,
    parameter int skip_not_ready_p = 0,
    localparam int lg_p            = (num_out_p > 1) ? $clog2(num_out_p) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 valid_i,
    input  logic [width_p-1:0]   data_i,
    output logic                 ready_o,
    output logic [num_out_p-1:0] valid_o,
    output logic [width_p-1:0]   data_o,
    input  logic [num_out_p-1:0] ready_i,
    output logic [lg_p-1:0]      ptr_o
);

    logic [width_p-1:0]   mem_q [2];
    logic                 wr_q;
    logic                 rd_q;
    logic [1:0]           occ_q;
    logic [lg_p-1:0]      ptr_q;
    logic                 init_q;   // low from reset until the first edge after release

    logic                 empty;
    logic                 enq;
    logic                 deq;
    logic [num_out_p-1:0] ready_rot;
    logic [lg_p-1:0]      offset;
    logic                 found;
    logic [lg_p:0]        sum;
    logic [lg_p-1:0]      target;
    logic [lg_p-1:0]      sel;
    logic [lg_p-1:0]      ptr_d;

    assign empty   = (occ_q == 2'd0);
    // init_q keeps ready_o low through the cycle in which reset is released,
    // so no word can be accepted on the deassertion edge.
    assign ready_o = init_q & ~occ_q[1];
    assign enq     = valid_i & ready_o;
    assign data_o  = mem_q[rd_q];
    assign ptr_o   = ptr_q;

    // ready_i rotated so that bit 0 corresponds to the channel at ptr_q.
    assign ready_rot = (ready_i >> ptr_q) | (ready_i << (num_out_p - int'(ptr_q)));

    // Skip-mode search: lowest set bit of the rotated ready vector, mapped
    // back to an absolute channel index modulo num_out_p.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        offset = '0;
        found  = 1'b0;
        for (int i = num_out_p - 1; i >= 0; i--) begin
            if (ready_rot[i]) begin
                found  = 1'b1;
                offset = lg_p'(i);
            end
        end
        sum = {1'b0, ptr_q} + {1'b0, offset};
        if (sum >= (lg_p + 1)'(num_out_p)) begin
            sum = sum - (lg_p + 1)'(num_out_p);
        end
        target = sum[lg_p-1:0];
    end

    always_comb begin
        sel   = ptr_q;
        deq   = 1'b0;
        ptr_d = ptr_q;
        if (skip_not_ready_p != 0) begin
            // With nobody ready, keep presenting the word at the pointer.
            sel = found ? target : ptr_q;
            deq = ~empty & found;
        end else begin
            deq = ~empty & ready_i[ptr_q];
        end
        if (deq) begin
            ptr_d = (sel == lg_p'(num_out_p - 1)) ? '0 : sel + 1'b1;
        end
    end

    always_comb begin
        valid_o = '0;
        if (!empty) begin
            valid_o[sel] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            occ_q  <= 2'd0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            ptr_q  <= '0;
            init_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
            ptr_q  <= ptr_d;
            if (enq) wr_q <= ~wr_q;
            if (deq) rd_q <= ~rd_q;
            case ({enq, deq})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // NOTE: payload storage has no reset; occupancy alone decides what is live.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_q] <= data_i;
    end

endmodule

// File: tb/tb_bsg_round_robin_1_to_n_buf.sv
// Self-checking bench for bsg_round_robin_1_to_n_buf.
//   dut_a : strict rotation, 3 channels
//   dut_b : skip-not-ready, 5 channels
// Vector rows give inputs plus expected valid_o / ready_o / ptr_o; payload
// order is tracked by a per-DUT scoreboard queue.
module tb_bsg_round_robin_1_to_n_buf;

    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic [4:0] rdy;
        logic [4:0] ev;   // expected valid_o
        logic       er;   // expected ready_o
        logic [2:0] ep;   // expected ptr_o
    } vec_t;

    logic       clk;
    logic       reset_n;

    logic       a_valid_i, a_ready_o;
    logic [7:0] a_data_i, a_data_o;
    logic [2:0] a_valid_o, a_ready_i;
    logic [1:0] a_ptr_o;

    logic       b_valid_i, b_ready_o;
    logic [7:0] b_data_i, b_data_o;
    logic [4:0] b_valid_o, b_ready_i;
    logic [2:0] b_ptr_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    vec_t ta[17];
    vec_t tb[10];

    bsg_round_robin_1_to_n_buf #(.num_out_p(3), .width_p(8), .skip_not_ready_p(0)) dut_a (
        .clk_i(clk), .reset_n_i(reset_n),
        .valid_i(a_valid_i), .data_i(a_data_i), .ready_o(a_ready_o),
        .valid_o(a_valid_o), .data_o(a_data_o), .ready_i(a_ready_i), .ptr_o(a_ptr_o)
    );

    bsg_round_robin_1_to_n_buf #(.num_out_p(5), .width_p(8), .skip_not_ready_p(1)) dut_b (
        .clk_i(clk), .reset_n_i(reset_n),
        .valid_i(b_valid_i), .data_i(b_data_i), .ready_o(b_ready_o),
        .valid_o(b_valid_o), .data_o(b_data_o), .ready_i(b_ready_i), .ptr_o(b_ptr_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic vld, input logic [7:0] dat, input logic [4:0] rdy,
                                input logic [4:0] ev, input logic er, input logic [2:0] ep);
        vec_t v;
        v.vld = vld; v.dat = dat; v.rdy = rdy; v.ev = ev; v.er = er; v.ep = ep;
        return v;
    endfunction

    task automatic apply_a(input vec_t v, input string tag);
        @(negedge clk);
        a_valid_i = v.vld;
        a_data_i  = v.dat;
        a_ready_i = v.rdy[2:0];
        #1;
        check({tag, " valid_o"}, 32'(a_valid_o), 32'(v.ev[2:0]));
        check({tag, " ready_o"}, 32'(a_ready_o), 32'(v.er));
        check({tag, " ptr_o"},   32'(a_ptr_o),   32'(v.ep[1:0]));
        if (v.ev != 5'd0) begin
            if (qa.size() == 0) begin
                check({tag, " scoreboard has word"}, 32'(0), 32'(1));
            end else begin
                check({tag, " data_o"}, 32'(a_data_o), 32'(qa[0]));
                if ((v.ev & v.rdy) != 5'd0) void'(qa.pop_front());
            end
        end
        if (v.vld && v.er) qa.push_back(v.dat);
    endtask

    task automatic apply_b(input vec_t v, input string tag);
        @(negedge clk);
        b_valid_i = v.vld;
        b_data_i  = v.dat;
        b_ready_i = v.rdy;
        #1;
        check({tag, " valid_o"}, 32'(b_valid_o), 32'(v.ev));
        check({tag, " ready_o"}, 32'(b_ready_o), 32'(v.er));
        check({tag, " ptr_o"},   32'(b_ptr_o),   32'(v.ep));
        if (v.ev != 5'd0) begin
            if (qb.size() == 0) begin
                check({tag, " scoreboard has word"}, 32'(0), 32'(1));
            end else begin
                check({tag, " data_o"}, 32'(b_data_o), 32'(qb[0]));
                if ((v.ev & v.rdy) != 5'd0) void'(qb.pop_front());
            end
        end
        if (v.vld && v.er) qb.push_back(v.dat);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " a valid_o"}, 32'(a_valid_o), 32'(0));
        check({tag, " a ready_o"}, 32'(a_ready_o), 32'(0));
        check({tag, " a ptr_o"},   32'(a_ptr_o),   32'(0));
        check({tag, " b valid_o"}, 32'(b_valid_o), 32'(0));
        check({tag, " b ready_o"}, 32'(b_ready_o), 32'(0));
        check({tag, " b ptr_o"},   32'(b_ptr_o),   32'(0));
    endtask

    initial begin
        // Strict, 3 channels: rotation/wrap, blocked channel, full FIFO, refill.
        ta[0]  = mk(1, 8'hA0, 5'b00111, 5'b00000, 1, 0);
        ta[1]  = mk(1, 8'hB1, 5'b00111, 5'b00001, 1, 0);
        ta[2]  = mk(1, 8'hC2, 5'b00111, 5'b00010, 1, 1);
        ta[3]  = mk(1, 8'hD3, 5'b00111, 5'b00100, 1, 2);
        ta[4]  = mk(0, 8'h00, 5'b00111, 5'b00001, 1, 0);
        ta[5]  = mk(0, 8'h00, 5'b00101, 5'b00000, 1, 1);
        ta[6]  = mk(1, 8'h58, 5'b00101, 5'b00000, 1, 1);
        ta[7]  = mk(1, 8'h59, 5'b00101, 5'b00010, 1, 1);
        ta[8]  = mk(1, 8'h57, 5'b00101, 5'b00010, 0, 1);
        ta[9]  = mk(1, 8'h57, 5'b00101, 5'b00010, 0, 1);
        ta[10] = mk(0, 8'h00, 5'b00111, 5'b00010, 0, 1);
        ta[11] = mk(1, 8'h5A, 5'b00111, 5'b00100, 1, 2);
        ta[12] = mk(0, 8'h00, 5'b00000, 5'b00001, 1, 0);
        ta[13] = mk(0, 8'h00, 5'b00000, 5'b00001, 1, 0);
        ta[14] = mk(0, 8'h00, 5'b00110, 5'b00001, 1, 0);
        ta[15] = mk(0, 8'h00, 5'b00001, 5'b00001, 1, 0);
        ta[16] = mk(0, 8'h00, 5'b00111, 5'b00000, 1, 1);

        // Skip, 5 channels: search from ptr=3 lands on 1, none ready, wrap 4->0.
        tb[0] = mk(1, 8'h70, 5'b00000, 5'b00000, 1, 0);
        tb[1] = mk(0, 8'h00, 5'b00100, 5'b00100, 1, 0);
        tb[2] = mk(1, 8'h71, 5'b00000, 5'b00000, 1, 3);
        tb[3] = mk(1, 8'h72, 5'b00000, 5'b01000, 1, 3);
        tb[4] = mk(1, 8'h73, 5'b00000, 5'b01000, 0, 3);
        tb[5] = mk(0, 8'h00, 5'b00110, 5'b00010, 0, 3);
        tb[6] = mk(0, 8'h00, 5'b00000, 5'b00100, 1, 2);
        tb[7] = mk(1, 8'h74, 5'b10000, 5'b10000, 1, 2);
        tb[8] = mk(0, 8'h00, 5'b11111, 5'b00001, 1, 0);
        tb[9] = mk(0, 8'h00, 5'b00000, 5'b00000, 1, 1);

        reset_n   = 1'b0;
        a_valid_i = 1'b1; a_data_i = 8'hEE; a_ready_i = 3'b111;
        b_valid_i = 1'b1; b_data_i = 8'hEE; b_ready_i = 5'b11111;
        #2;
        check_reset_outputs("rst0");
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst1");
        #2 reset_n = 1'b1;
        #1;
        check_reset_outputs("release");   // deassertion cycle: no acceptance yet
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;

        for (int i = 0; i < 17; i++) apply_a(ta[i], $sformatf("a%0d", i));
        for (int i = 0; i < 10; i++) apply_b(tb[i], $sformatf("b%0d", i));

        // Skip mode, all ready: one word per cycle, rotating from ptr=1.
        for (int k = 0; k < 7; k++) begin
            vec_t v;
            v = mk(k < 6, 8'(8'h60 + k), 5'b11111,
                   (k == 0) ? 5'b00000 : 5'(5'b00001 << (k % 5)), 1,
                   (k == 0) ? 3'd1 : 3'(k % 5));
            apply_b(v, $sformatf("burst%0d", k));
        end

        // Two words buffered in dut_a (ptr=1), then reset mid-cycle.
        apply_a(mk(1, 8'hE1, 5'b00000, 5'b00000, 1, 1), "fill0");
        apply_a(mk(1, 8'hE2, 5'b00000, 5'b00010, 1, 1), "fill1");
        @(negedge clk);
        a_valid_i = 1'b0;
        #1;
        check("full a ready_o", 32'(a_ready_o), 32'(0));
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        qa.delete();
        qb.delete();
        a_valid_i = 1'b1; a_data_i = 8'hF0; a_ready_i = 3'b111;
        @(negedge clk);
        check_reset_outputs("hold0");
        @(negedge clk);
        check_reset_outputs("hold1");
        #2 reset_n = 1'b1;
        #1;
        check("release2 a ready_o", 32'(a_ready_o), 32'(0));
        apply_a(mk(1, 8'hF1, 5'b00111, 5'b00000, 1, 0), "post0");
        apply_a(mk(0, 8'h00, 5'b00111, 5'b00001, 1, 0), "post1");
        apply_a(mk(0, 8'h00, 5'b00111, 5'b00000, 1, 1), "post2");

        check("a scoreboard drained", 32'(qa.size()), 32'(0));
        check("b scoreboard drained", 32'(qb.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bsg_round_robin_1_to_n_buf.md
BSG_ROUND_ROBIN_1_TO_N_BUF -- requirements
Module: bsg_round_robin_1_to_n_buf

Interface
REQ-001 SHALL have parameter num_out_p, default 4, number of output channels; legal 2..64, need not be a power of two.
REQ-002 SHALL have parameter width_p, default 8, payload width in bits.
REQ-003 SHALL have parameter skip_not_ready_p, default 0; 0 = strict rotation, 1 = skip channels that are not ready.
REQ-004 SHALL define ptr width lg_p = ceil(log2(num_out_p)), minimum 1.
REQ-005 Port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-006 Port: reset_n_i  input  1  asynchronous, active-low reset.
REQ-007 Port: valid_i  input  1  upstream data valid.
REQ-008 Port: data_i  input  width_p  upstream payload.
REQ-009 Port: ready_o  output  1  block can accept a word this cycle.
REQ-010 Port: valid_o  output  num_out_p  one-hot or zero; valid to each channel.
REQ-011 Port: data_o  output  width_p  payload broadcast to all channels.
REQ-012 Port: ready_i  input  num_out_p  per-channel downstream ready.
REQ-013 Port: ptr_o  output  lg_p  current rotation pointer, from a register.

Function
REQ-014 SHALL buffer input words in a 2-entry FIFO; enqueue when valid_i & ready_o.
REQ-015 ready_o SHALL equal (occupancy < 2), depending only on registered state, with no combinational path from ready_i or valid_i.
REQ-016 SHALL provide no bypass: a word enqueued in cycle t is first presented on valid_o/data_o in cycle t+1.
REQ-017 data_o SHALL show the FIFO head whenever occupancy > 0; when empty its value is don't-care.
REQ-018 When empty, valid_o SHALL be all zero.
REQ-019 Strict mode (skip_not_ready_p=0): when non-empty, valid_o SHALL be one-hot at ptr; dequeue SHALL occur iff ready_i[ptr].
REQ-020 Skip mode (skip_not_ready_p=1): the target SHALL be the first index at or after ptr, searching cyclically, with ready_i set.
REQ-021 Skip mode, non-empty with a target: valid_o SHALL be one-hot at the target, and dequeue SHALL occur.
REQ-022 Skip mode, non-empty with no ready_i set: valid_o SHALL be one-hot at ptr; no dequeue.
REQ-023 On dequeue, ptr SHALL become (sent index + 1) mod num_out_p, wrapping from num_out_p-1 to 0; otherwise ptr holds.
REQ-024 Simultaneous enqueue and dequeue SHALL keep occupancy unchanged and preserve FIFO order.
REQ-025 At occupancy 2, valid_i SHALL be ignored and no word lost or overwritten.
REQ-026 ready_i bits for non-selected channels SHALL have no effect on state.
REQ-027 Throughput SHALL be one word per cycle sustained when the targeted channels are ready.

Reset
REQ-028 While reset_n_i=0: occupancy=0, ptr=0, valid_o=0, ready_o=0, ptr_o=0, regardless of clock.
REQ-029 Reset assertion SHALL take effect immediately; buffered words SHALL be discarded.
REQ-030 ready_o SHALL rise in the first cycle after reset_n_i deasserts.
REQ-031 Deassertion SHALL be used synchronously to clk_i, and no transfer SHALL occur in the deassertion cycle.

Verification
REQ-032 Strict, num_out_p=3, all ready_i=1, send A,B,C,D back-to-back -> valid_o 001,010,100,001 on consecutive cycles carrying A..D; ptr_o wraps 2->0.
REQ-033 Strict, num_out_p=3, ptr=1, ready_i=101, one word X -> valid_o=010 held, X not taken; ready_o=0 after a third word; ready_i=111 -> X delivered, ptr_o=2.
REQ-034 Skip, num_out_p=5, ptr=3, ready_i=00110 -> valid_o=00010 with the head word delivered to channel 1, ptr_o becomes 2.
REQ-035 Skip, ready_i=0 with the FIFO non-empty -> valid_o one-hot at ptr, no dequeue, occupancy and ptr unchanged.
REQ-036 FIFO holding 2 words, valid_i=1 and ready_o=0 -> no enqueue; then one dequeue plus enqueue Z the next cycle -> order preserved, occupancy stays 1 at the following steady state.
REQ-037 reset_n_i pulsed low mid-clock with 2 words buffered -> valid_o=0 and ptr_o=0 immediately; old words never appear after release.
